swap_write_demux: RTL and testbench
===================================

Name: swap_write_demux

Overview:
- Registered 1-to-2 write demultiplexer with valid/ready handshakes.
- Steers one incoming write beat (address + data) to memory write port A or port B, selected per beat by `sel`.
- Write-side counterpart of the 2:1 read-select mux in the memory swapper datapath: the mux picks which bank is read; this block decides which bank receives the write-back.
- Each output channel has a one-entry holding register, so a stalled bank does not block writes to the other bank.

Parameters:
- n, 1, data width in bits
- AW, 4, address width in bits
- CW, 8, width of each per-channel completed-write counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept the beat presented this cycle
- sel  input  1  destination select: 0 = port A, 1 = port B; qualified by in_valid
- in_addr  input  AW  write address
- in_data  input  n  write data
- a_valid  output  1  port A beat valid
- a_ready  input  1  port A accepts beat
- a_addr  output  AW  port A address
- a_data  output  n  port A data
- b_valid  output  1  port B beat valid
- b_ready  input  1  port B accepts beat
- b_addr  output  AW  port B address
- b_data  output  n  port B data
- a_count  output  CW  completed writes on port A
- b_count  output  CW  completed writes on port B
- busy  output  1  a_valid | b_valid

Behaviour:
- Reset: one clock, synchronous, active-low.
  - When rst_n=0 at a rising edge: a_valid, b_valid, a_addr, b_addr, a_data, b_data, a_count, b_count all become 0.
  - in_ready = 0 combinationally while rst_n=0.
  - A reset asserted while beats are held discards those beats; no handshake is reported and the counts do not increment.
- Channel states: each channel X in {A, B} is EMPTY (X_valid=0) or FULL (X_valid=1). X_valid is a register output.
- in_ready (combinational):
  - sel=0: in_ready = rst_n & (~a_valid | a_ready)
  - sel=1: in_ready = rst_n & (~b_valid | b_ready)
  - in_ready depends on sel, not on in_valid.
- Accept: occurs on a rising edge where in_valid & in_ready. The target register loads in_addr/in_data and X_valid=1 the following cycle. Latency is exactly 1 cycle, input handshake to output valid.
- Drain: occurs on a rising edge where X_valid & X_ready. If no load targets X in the same edge, X_valid goes to 0.
- Drain and load on the same edge for the same channel: the register reloads with the new beat, X_valid stays 1, X_count increments. Full throughput is one beat per cycle per channel.
- Non-selected channel: the register, valid and count of the other channel are unaffected by an accept.
- Stability: while X_valid=1 and X_ready=0, X_addr and X_data hold constant. X_valid never deasserts without a handshake, except on reset.
- X_data/X_addr when EMPTY hold the last drained beat; they are don't-care for the bench.
- Counters: X_count increments by 1 on each X_valid & X_ready edge and wraps modulo 2^CW (for CW=8: 255 -> 0, no saturation).
- Ordering:
  - Beats to the same channel leave in acceptance order.
  - There is no ordering guarantee between channels.
- sel/in_addr/in_data are sampled only on an accept edge. Changing sel while in_valid=1 and in_ready=0 is legal; in_ready re-evaluates against the new sel.
- busy is combinational: a_valid | b_valid.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0; all valids, addr, data and counts are 0. Release -> in_ready=1 on the first cycle.
- Basic steer: n=8, send (sel=0, addr=3, data=0xA5), then (sel=1, addr=7, data=0x5A), with a_ready=b_ready=1.
  - a_valid is high exactly 1 cycle after the first accept, with a_addr=3, a_data=0xA5.
  - b_valid follows one cycle later with b_addr=7, b_data=0x5A.
  - a_count=1, b_count=1.
- Backpressure isolation: hold a_ready=0, load A with 0x11, then present sel=0 data 0x22.
  - in_ready=0; a_data remains 0x11.
  - Switch sel=1 data 0x33 -> accepted; b_data=0x33 while A is still stalled.
  - Release a_ready -> 0x11 drains, then 0x22 is accepted.
- Back-to-back: 10 consecutive sel=0 beats 0..9 with a_ready=1 every cycle -> in_ready stays 1 throughout, a_valid is continuous for 10 cycles, data appears in order 0..9, a_count=10.
- Counter wrap: 256 beats to B -> b_count goes 255 -> 0; a_count is unchanged.
- Reset mid-operation: A and B both FULL with ready=0, assert rst_n=0 for one edge -> both valids are 0 the next cycle and counts are 0. After release, a new beat to A is delivered normally.

Source files
------------

// File: rtl/swap_write_demux.sv
// swap_write_demux: registered 1-to-2 write demux steering each beat to bank A or B,
// with a one-entry holding register per bank so a stalled bank never blocks the other.
module swap_write_demux #(
    parameter int n  = 1,
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sel,
    input  logic [AW-1:0] in_addr,
    input  logic [n-1:0]  in_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [AW-1:0] a_addr,
    output logic [n-1:0]  a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [AW-1:0] b_addr,
    output logic [n-1:0]  b_data,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count,
    output logic          busy
);
    logic          r_a_valid, r_b_valid;
    logic [AW-1:0] r_a_addr, r_b_addr;
    logic [n-1:0]  r_a_data, r_b_data;
    logic [CW-1:0] r_a_count, r_b_count;
    logic          w_a_free, w_b_free, w_load_a, w_load_b, w_drain_a, w_drain_b;

    // a slot can take a new beat when empty or draining on this same edge
    assign w_a_free  = ~r_a_valid | a_ready;
    assign w_b_free  = ~r_b_valid | b_ready;
    assign in_ready  = rst_n & (sel ? w_b_free : w_a_free);
    assign w_load_a  = in_valid & in_ready & ~sel;
    assign w_load_b  = in_valid & in_ready & sel;
    assign w_drain_a = r_a_valid & a_ready;
    assign w_drain_b = r_b_valid & b_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_addr  <= '0;
            r_b_addr  <= '0;
            r_a_data  <= '0;
            r_b_data  <= '0;
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            r_a_valid <= w_load_a | (r_a_valid & ~a_ready);
            r_b_valid <= w_load_b | (r_b_valid & ~b_ready);
            if (w_load_a) begin
                r_a_addr <= in_addr;
                r_a_data <= in_data;
            end
            if (w_load_b) begin
                r_b_addr <= in_addr;
                r_b_data <= in_data;
            end
            if (w_drain_a) r_a_count <= r_a_count + CW'(1);
            if (w_drain_b) r_b_count <= r_b_count + CW'(1);
        end
    end

    assign a_valid = r_a_valid;
    assign b_valid = r_b_valid;
    assign a_addr  = r_a_addr;
    assign b_addr  = r_b_addr;
    assign a_data  = r_a_data;
    assign b_data  = r_b_data;
    assign a_count = r_a_count;
    assign b_count = r_b_count;
    assign busy    = r_a_valid | r_b_valid;
endmodule

// File: tb/tb_swap_write_demux.sv
// tb_swap_write_demux: vector table, directed corner sequences and randomized traffic
// checked against a queue-based model of the two holding slots.
module tb_swap_write_demux;
    localparam int N  = 8;
    localparam int AW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, sel, a_ready, b_ready;
    logic [AW-1:0] in_addr, a_addr, b_addr;
    logic [N-1:0]  in_data, a_data, b_data;
    logic          a_valid, b_valid, busy;
    logic [CW-1:0] a_count, b_count;

    int tests = 0;
    int fails = 0;

    // model: each slot is a queue holding at most one {addr,data} beat
    logic [AW+N-1:0] qa[$];
    logic [AW+N-1:0] qb[$];
    int ca = 0;
    int cb = 0;

    swap_write_demux #(.n(N), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .in_addr(in_addr), .in_data(in_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .a_count(a_count), .b_count(b_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic [AW-1:0] ad,
                         input logic [N-1:0] d, input logic ar, input logic br);
        rst_n = r; in_valid = v; sel = s; in_addr = ad; in_data = d; a_ready = ar; b_ready = br;
    endtask

    // one clock: check combinational outputs mid-cycle, advance model, check registers after edge
    task automatic tick();
        logic exp_ir;
        @(negedge clk);
        exp_ir = rst_n && (sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready));
        chk("model_in_ready", in_ready, exp_ir);
        chk("model_busy", busy, qa.size() != 0 || qb.size() != 0);
        @(posedge clk);
        if (!rst_n) begin
            qa.delete(); qb.delete(); ca = 0; cb = 0;
        end else begin
            if (qa.size() != 0 && a_ready) begin void'(qa.pop_front()); ca = (ca + 1) % 256; end
            if (qb.size() != 0 && b_ready) begin void'(qb.pop_front()); cb = (cb + 1) % 256; end
            if (in_valid && exp_ir) begin
                if (sel) qb.push_back({in_addr, in_data});
                else     qa.push_back({in_addr, in_data});
            end
        end
        #1;
        chk("model_a_valid", a_valid, qa.size() != 0);
        chk("model_b_valid", b_valid, qb.size() != 0);
        if (qa.size() != 0) chk("model_a_beat", {a_addr, a_data}, qa[0]);
        if (qb.size() != 0) chk("model_b_beat", {b_addr, b_data}, qb[0]);
        chk("model_a_count", a_count, ca);
        chk("model_b_count", b_count, cb);
    endtask

    typedef struct {
        logic          r, v, s;
        logic [AW-1:0] ad;
        logic [N-1:0]  d;
        logic          ar, br, eir, eav, ebv;
        logic [AW-1:0] eaa, eba;
        logic [N-1:0]  ead, ebd;
        logic [CW-1:0] eac, ebc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [CW-1:0] a_base, b_base, prev_b;
        logic          seen_wrap;
        tbl[0]  = '{0, 1, 0, 4'h5, 8'hFF, 1, 1, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 8'd0, 8'd0};
        tbl[1]  = '{0, 1, 1, 4'h6, 8'hEE, 1, 1, 0, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 8'd0, 8'd0};
        tbl[2]  = '{1, 0, 0, 4'h0, 8'h00, 1, 1, 1, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 8'd0, 8'd0};
        tbl[3]  = '{1, 1, 0, 4'h3, 8'hA5, 1, 1, 1, 1, 0, 4'h3, 4'h0, 8'hA5, 8'h00, 8'd0, 8'd0};
        tbl[4]  = '{1, 1, 1, 4'h7, 8'h5A, 1, 1, 1, 0, 1, 4'h0, 4'h7, 8'h00, 8'h5A, 8'd1, 8'd0};
        tbl[5]  = '{1, 0, 0, 4'h0, 8'h00, 1, 1, 1, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 8'd1, 8'd1};
        tbl[6]  = '{1, 1, 0, 4'h1, 8'h11, 0, 1, 1, 1, 0, 4'h1, 4'h0, 8'h11, 8'h00, 8'd1, 8'd1};
        tbl[7]  = '{1, 1, 0, 4'h2, 8'h22, 0, 1, 0, 1, 0, 4'h1, 4'h0, 8'h11, 8'h00, 8'd1, 8'd1};
        tbl[8]  = '{1, 1, 1, 4'h3, 8'h33, 0, 0, 1, 1, 1, 4'h1, 4'h3, 8'h11, 8'h33, 8'd1, 8'd1};
        tbl[9]  = '{1, 1, 0, 4'h2, 8'h22, 1, 0, 1, 1, 1, 4'h2, 4'h3, 8'h22, 8'h33, 8'd2, 8'd1};
        tbl[10] = '{1, 0, 0, 4'h0, 8'h00, 1, 1, 1, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 8'd3, 8'd2};
        drive(0, 0, 0, '0, '0, 1, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].ad, tbl[i].d, tbl[i].ar, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_a_valid", i), a_valid, tbl[i].eav);
            chk($sformatf("vec%0d_b_valid", i), b_valid, tbl[i].ebv);
            if (tbl[i].eav || !tbl[i].r) chk($sformatf("vec%0d_a_beat", i), {a_addr, a_data}, {tbl[i].eaa, tbl[i].ead});
            if (tbl[i].ebv || !tbl[i].r) chk($sformatf("vec%0d_b_beat", i), {b_addr, b_data}, {tbl[i].eba, tbl[i].ebd});
            chk($sformatf("vec%0d_a_count", i), a_count, tbl[i].eac);
            chk($sformatf("vec%0d_b_count", i), b_count, tbl[i].ebc);
        end
        // model takes over from a clean reset
        drive(0, 0, 0, '0, '0, 1, 1);
        tick();
        // back-to-back beats to A
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, AW'(i), N'(i), 1, 1);
            tick();
            chk("b2b_a_valid", a_valid, 1'b1);
            chk("b2b_a_data", a_data, i);
        end
        drive(1, 0, 0, '0, '0, 1, 1);
        tick();
        chk("b2b_a_count", a_count, 10);
        // 256 beats to B wrap its counter
        a_base = a_count;
        b_base = b_count;
        seen_wrap = 1'b0;
        for (int i = 0; i < 257; i++) begin
            prev_b = b_count;
            drive(1, i < 256, 1, AW'(i), N'(i * 3), 1, 1);
            tick();
            if (prev_b == 8'd255 && b_count == 8'd0) seen_wrap = 1'b1;
        end
        chk("wrap_seen", seen_wrap, 1'b1);
        chk("wrap_b_count", b_count, b_base);
        chk("wrap_a_count", a_count, a_base);
        // reset while both slots are full and stalled
        drive(1, 1, 0, 4'h9, 8'h99, 0, 0);
        tick();
        drive(1, 1, 1, 4'hA, 8'hAA, 0, 0);
        tick();
        chk("mid_both_full", {a_valid, b_valid}, 2'b11);
        drive(0, 1, 0, 4'hB, 8'hBB, 0, 0);
        tick();
        chk("mid_rst_valids", {a_valid, b_valid}, 2'b00);
        chk("mid_rst_counts", {a_count, b_count}, 16'h0);
        drive(1, 1, 0, 4'hC, 8'hCC, 1, 1);
        tick();
        chk("mid_new_beat", {a_valid, a_addr, a_data}, {1'b1, 4'hC, 8'hCC});
        drive(1, 0, 0, '0, '0, 1, 1);
        tick();
        chk("mid_new_count", a_count, 1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(63) != 0, 1'($urandom), 1'($urandom), AW'($urandom), N'($urandom),
                  1'($urandom), $urandom_range(3) != 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
